// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: boot vector, FSM encoding
// and the layout of a buffered fetch entry.
package riscv_fetch_pkg;

  localparam logic [31:0] BOOT_VECTOR_DEFAULT = 32'h8000_0000;
  localparam int unsigned FIFO_W              = 65;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_DRAIN = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Two-entry skid FIFO between the icache response and decode. The head entry is
// a flop so decode always sees registered data.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [FIFO_W-1:0] wr_data,
  output logic [FIFO_W-1:0] rd_data,
  output logic              valid,
  output logic              full,
  output logic [1:0]        count
);

  logic [FIFO_W-1:0] head_q;
  logic [FIFO_W-1:0] tail_q;
  logic [1:0]        count_q;
  logic              pop_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign rd_data = head_q;
  assign valid   = (count_q != 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;

  // Storage and occupancy; a clear wins over any push in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= {FIFO_W{1'b0}};
      tail_q  <= {FIFO_W{1'b0}};
      count_q <= 2'd0;
    end else if (clear) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q  <= wr_data;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= wr_data;
            count_q <= 2'd2;
          end else begin
            count_q <= count_q;
          end
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= wr_data;
          end else begin
            head_q <= tail_q;
            tail_q <= wr_data;
          end
        end
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: sequential/redirected PC generation, single outstanding icache
// lookup with stale-response dropping, decode FIFO and fence.i flush sequencing.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_VECTOR = BOOT_VECTOR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic        fence_i_i,
  input  logic [31:0] fence_pc_i,
  input  logic        fetch_accept_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  output logic        icache_rd_o,
  output logic        icache_flush_o,
  output logic        icache_invalidate_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic [31:0] icache_inst_i
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  tag_pc_q;
  logic [31:0]  fence_pc_q;
  logic         out_q;
  logic         drop_q;

  logic [31:0]  branch_target;
  logic [1:0]   count_q;
  logic [2:0]   occupancy;
  logic         fifo_valid;
  logic         fifo_full;
  logic         pop;
  logic         push;
  logic         clear;
  logic         resp;
  logic         issue;
  logic         fence_start;
  logic [FIFO_W-1:0] fifo_rd_data;
  fetch_entry_t head;

  assign branch_target = branch_pc_i & 32'hFFFF_FFFC;
  assign pop           = fifo_valid && fetch_accept_i;
  // Buffered plus in-flight entries must leave room for the next response.
  assign occupancy     = {1'b0, count_q} + {2'b00, out_q} - {2'b00, pop};
  assign resp          = icache_valid_i && out_q;
  assign icache_rd_o   = !rst_i && (state_q == FETCH_RUN) && !branch_request_i && (occupancy < 3'd2);
  assign issue         = icache_rd_o && icache_accept_i;
  assign fence_start   = (state_q == FETCH_RUN) && fence_i_i;
  assign clear         = branch_request_i || fence_start;
  assign push          = resp && !drop_q && !branch_request_i && (state_q == FETCH_RUN) && !fifo_full;

  riscv_fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wr_data ({icache_inst_i, tag_pc_q, icache_error_i}),
    .rd_data (fifo_rd_data),
    .valid   (fifo_valid),
    .full    (fifo_full),
    .count   (count_q)
  );

  assign head                = fetch_entry_t'(fifo_rd_data);
  assign fetch_valid_o       = fifo_valid;
  assign fetch_instr_o       = head.instr;
  assign fetch_pc_o          = head.pc;
  assign fetch_fault_o       = head.fault;
  assign icache_flush_o      = (state_q == FETCH_FLUSH);
  assign icache_invalidate_o = 1'b0;
  assign icache_pc_o         = pc_q;

  // PC, outstanding-lookup tracking and fence FSM; a branch overrides the PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= FETCH_RUN;
      pc_q       <= BOOT_VECTOR;
      tag_pc_q   <= 32'h0000_0000;
      fence_pc_q <= 32'h0000_0000;
      out_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (issue) begin
        out_q    <= 1'b1;
        tag_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end else if (resp) begin
        out_q <= 1'b0;
      end else begin
        out_q <= out_q;
      end

      if (branch_request_i && out_q && !resp) begin
        drop_q <= 1'b1;
      end else if (resp) begin
        drop_q <= 1'b0;
      end else begin
        drop_q <= drop_q;
      end

      if (branch_request_i) begin
        pc_q <= branch_target;
      end

      case (state_q)
        FETCH_RUN: begin
          if (fence_i_i) begin
            state_q    <= FETCH_DRAIN;
            fence_pc_q <= branch_request_i ? branch_target : fence_pc_i;
          end
        end
        FETCH_DRAIN: begin
          if (branch_request_i) fence_pc_q <= branch_target;
          if (!out_q) state_q <= FETCH_FLUSH;
        end
        FETCH_FLUSH: begin
          if (branch_request_i) fence_pc_q <= branch_target;
          if (icache_accept_i) begin
            state_q <= FETCH_RUN;
            pc_q    <= branch_request_i ? branch_target : fence_pc_q;
          end
        end
        default: state_q <= FETCH_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with a behavioural icache and a response scoreboard.
module tb_riscv_fetch;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic        fence_i_i;
  logic [31:0] fence_pc_i;
  logic        fetch_accept_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_o;
  logic        icache_rd_o;
  logic        icache_flush_o;
  logic        icache_invalidate_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic        icache_error_i;
  logic [31:0] icache_inst_i;

  always #5 clk_i = ~clk_i;

  riscv_fetch #(.BOOT_VECTOR(BOOT)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .branch_request_i    (branch_request_i),
    .branch_pc_i         (branch_pc_i),
    .fence_i_i           (fence_i_i),
    .fence_pc_i          (fence_pc_i),
    .fetch_accept_i      (fetch_accept_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_fault_o       (fetch_fault_o),
    .icache_rd_o         (icache_rd_o),
    .icache_flush_o      (icache_flush_o),
    .icache_invalidate_o (icache_invalidate_o),
    .icache_pc_o         (icache_pc_o),
    .icache_accept_i     (icache_accept_i),
    .icache_valid_i      (icache_valid_i),
    .icache_error_i      (icache_error_i),
    .icache_inst_i       (icache_inst_i)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [64:0] sb[$];

  // Inputs requested for the next cycle.
  logic        nx_rst = 1'b1, nx_branch = 1'b0, nx_fence = 1'b0, nx_accept = 1'b1;
  logic [31:0] nx_branch_pc = 32'h0, nx_fence_pc = 32'h0;

  // Behavioural icache: one lookup at a time, miss_lat extra cycles per lookup.
  logic        pend = 1'b0;
  logic        resp_now = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  int          pend_epoch = 0, wait_cnt = 0, miss_lat = 0, epoch = 0, flushes = 0;
  logic [31:0] err_pc = 32'h8000_0010;
  logic [31:0] hold_pc;

  function automatic logic [31:0] model_instr(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hC0DE, pc[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {64'h0, obs}, {64'h0, exp});
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, {33'h0, obs}, {33'h0, exp});
  endtask

  // One clock cycle: apply inputs after the edge, sample mid-cycle, update scoreboard and cache model.
  task automatic tick();
    logic keep;
    int   ep0;
    @(posedge clk_i);
    #1;
    rst_i            = nx_rst;
    branch_request_i = nx_branch;
    branch_pc_i      = nx_branch_pc;
    fence_i_i        = nx_fence;
    fence_pc_i       = nx_fence_pc;
    fetch_accept_i   = nx_accept;
    nx_branch        = 1'b0;
    nx_fence         = 1'b0;
    resp_now         = pend && (wait_cnt == 0);
    icache_valid_i   = resp_now;
    icache_inst_i    = resp_now ? model_instr(pend_pc) : 32'h0;
    icache_error_i   = resp_now && (pend_pc == err_pc);
    icache_accept_i  = !pend || resp_now;
    #1;
    ep0 = epoch;
    chk1("valid_vs_scoreboard", fetch_valid_o, sb.size() != 0);
    if (fetch_valid_o && sb.size() != 0) begin
      chk("head_entry", {fetch_instr_o, fetch_pc_o, fetch_fault_o}, sb[0]);
      if (fetch_accept_i) void'(sb.pop_front());
    end
    keep = resp_now && (pend_epoch == epoch) && !branch_request_i && !fence_i_i;
    if (branch_request_i || fence_i_i) begin
      sb.delete();
      epoch++;
    end
    if (keep) sb.push_back({icache_inst_i, pend_pc, icache_error_i});
    chk1("fifo_never_overfills", sb.size() <= 2, 1'b1);
    if (resp_now) pend = 1'b0;
    else if (pend) wait_cnt--;
    if (icache_rd_o && icache_accept_i) begin
      pend       = 1'b1;
      pend_pc    = icache_pc_o;
      pend_epoch = ep0;
      wait_cnt   = miss_lat;
    end
    if (icache_flush_o && icache_accept_i) flushes++;
  endtask

  initial begin
    rst_i = 1'b1; branch_request_i = 1'b0; branch_pc_i = 32'h0; fence_i_i = 1'b0;
    fence_pc_i = 32'h0; fetch_accept_i = 1'b1; icache_accept_i = 1'b0;
    icache_valid_i = 1'b0; icache_error_i = 1'b0; icache_inst_i = 32'h0;

    // Reset values
    tick(); tick();
    chk1("rst_fetch_valid", fetch_valid_o, 1'b0);
    chk32("rst_fetch_instr", fetch_instr_o, 32'h0);
    chk32("rst_fetch_pc", fetch_pc_o, 32'h0);
    chk1("rst_fetch_fault", fetch_fault_o, 1'b0);
    chk1("rst_icache_rd", icache_rd_o, 1'b0);
    chk1("rst_icache_flush", icache_flush_o, 1'b0);
    chk1("rst_icache_invalidate", icache_invalidate_o, 1'b0);
    chk32("rst_icache_pc", icache_pc_o, BOOT);

    // First request right after reset, then sequential hits with decode ready
    nx_rst = 1'b0;
    tick();
    chk1("first_rd", icache_rd_o, 1'b1);
    chk32("first_req_pc", icache_pc_o, BOOT);
    tick();
    chk1("latency_not_yet_valid", fetch_valid_o, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1("stream_valid", fetch_valid_o, 1'b1);
      chk32("stream_pc", fetch_pc_o, BOOT + 32'(4 * k));
      chk1("stream_fault", fetch_fault_o, k == 4);
    end

    // Decode stall: two entries buffered, issue stops, head held stable
    nx_accept = 1'b0;
    tick();
    hold_pc = fetch_pc_o;
    for (int k = 0; k < 4; k++) tick();
    chk1("stall_rd_low", icache_rd_o, 1'b0);
    chk1("stall_valid", fetch_valid_o, 1'b1);
    chk32("stall_head_stable", fetch_pc_o, hold_pc);
    nx_accept = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk32("release_order", fetch_pc_o, hold_pc + 32'(4 * k));
    end

    // Branch to 0x1002 while a miss is outstanding
    miss_lat = 4;
    tick(); tick();
    nx_branch = 1'b1; nx_branch_pc = 32'h0000_1002;
    tick();
    miss_lat = 0;
    tick();
    chk32("redirect_req_pc", icache_pc_o, 32'h0000_1000);
    for (int i = 0; i < 30 && !fetch_valid_o; i++) tick();
    chk1("redirect_valid_timeout", fetch_valid_o, 1'b1);
    chk32("redirect_first_pc", fetch_pc_o, 32'h0000_1000);

    // Branch in the same cycle as a hit response
    tick(); tick(); tick();
    nx_branch = 1'b1; nx_branch_pc = 32'h0000_3000;
    tick();
    tick();
    chk1("same_cycle_branch_empty", fetch_valid_o, 1'b0);
    for (int i = 0; i < 30 && !fetch_valid_o; i++) tick();
    chk1("branch2_valid_timeout", fetch_valid_o, 1'b1);
    chk32("branch2_first_pc", fetch_pc_o, 32'h0000_3000);

    // fence.i during an outstanding lookup
    tick(); tick(); tick();
    miss_lat = 3;
    tick(); tick();
    nx_fence = 1'b1; nx_fence_pc = 32'h0000_2000;
    tick();
    miss_lat = 0;
    for (int i = 0; i < 30 && flushes == 0; i++) begin
      tick();
      chk1("drain_no_issue", icache_rd_o, 1'b0);
    end
    chk32("flush_accepted", 32'(flushes), 32'd1);
    tick();
    chk1("post_fence_rd", icache_rd_o, 1'b1);
    chk32("post_fence_pc", icache_pc_o, 32'h0000_2000);
    for (int i = 0; i < 30 && !fetch_valid_o; i++) tick();
    chk1("fence_valid_timeout", fetch_valid_o, 1'b1);
    chk32("fence_first_pc", fetch_pc_o, 32'h0000_2000);
    chk32("single_flush", 32'(flushes), 32'd1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch stage directly upstream of the instruction cache. It generates sequential and redirected PCs and issues lookups on the cache request port. Returned instructions are buffered in a 2-entry FIFO for the decode stage, and responses made stale by a branch are discarded. It also sequences `fence.i` cache flushes.

## Interface
- `BOOT_VECTOR`, 32'h8000_0000, PC fetched first after reset
- `clk_i` in 1: clock
- `rst_i` in 1: reset, asynchronous, active-high
- `branch_request_i` in 1: redirect fetch (single-cycle pulse)
- `branch_pc_i` in 32: redirect target, bits [1:0] ignored (forced 0)
- `fence_i_i` in 1: `fence.i` request pulse
- `fence_pc_i` in 32: PC to resume at after the fence
- `fetch_accept_i` in 1: decode takes the head instruction
- `fetch_valid_o` out 1: head instruction valid
- `fetch_instr_o` out 32: instruction
- `fetch_pc_o` out 32: PC of the instruction
- `fetch_fault_o` out 1: cache reported an error for this fetch
- `icache_rd_o` out 1: lookup request
- `icache_flush_o` out 1: full-cache flush request
- `icache_invalidate_o` out 1: tied 0
- `icache_pc_o` out 32: lookup PC (word aligned)
- `icache_accept_i` in 1: cache accepts rd/flush this cycle
- `icache_valid_i` in 1: lookup result valid
- `icache_error_i` in 1: lookup error
- `icache_inst_i` in 32: lookup instruction

## Operation
- **State**
  - `pc_q`: next PC to request; resets to `BOOT_VECTOR`.
  - `out_q` (0/1): a request is accepted but its result has not returned.
  - `drop_q`: the outstanding result is stale.
  - `tag_pc_q`: PC of the outstanding request.
- **Issue.** `icache_rd_o = state==RUN && !branch_request_i && credit`.
  - `credit = count_q + out_q - pop < 2`, where `pop = fetch_valid_o && fetch_accept_i`.
  - On `icache_rd_o && icache_accept_i`: `out_q<=1`, `tag_pc_q<=pc_q`, `pc_q<=pc_q+4` (mod 2^32 wrap).
- **Response.** When `icache_valid_i && out_q`:
  - `out_q` clears, unless a new request is accepted in the same cycle.
  - If `!drop_q` and no branch this cycle, push {`icache_inst_i`, `tag_pc_q`, `icache_error_i`} into the FIFO.
  - Otherwise discard it and clear `drop_q`.
  - `icache_valid_i` with `out_q==0` is ignored.
- **Branch.** `branch_request_i` has priority over everything in that cycle:
  - `pc_q<=branch_pc_i&~3`.
  - FIFO cleared, so `fetch_valid_o` is 0 next cycle.
  - If `out_q` and no response this cycle, `drop_q<=1`.
  - No issue in the branch cycle.
  - A branch during DRAIN/FLUSH updates `fence_pc`, i.e. the last redirect wins.
- **FSM.** Reset state RUN.
  - RUN -> DRAIN on `fence_i_i`. Captures `fence_pc_i` and clears the FIFO.
  - DRAIN: no issue. Waits for `out_q==0`; the returning response is discarded. Then -> FLUSH.
  - FLUSH: `icache_flush_o=1`. On `icache_accept_i`, `pc_q<=fence_pc`, -> RUN.
  - `fence_i_i` outside RUN is ignored.
- **Fault.** `fetch_fault_o` travels with its entry. Fetch continues sequentially and does not stall on a fault; decode raises the trap and redirects.
- **FIFO.** 2 entries, head registered, push/pop in the same cycle allowed.
  - Push when full cannot occur because of the credit rule; the bench must check this invariant.
  - Clear beats push.

## Timing
- **Reset values.**
  - Outputs: `fetch_valid_o=0`, `fetch_instr_o=0`, `fetch_pc_o=0`, `fetch_fault_o=0`, `icache_rd_o=0`, `icache_flush_o=0`, `icache_pc_o=BOOT_VECTOR`.
  - Registers: `count_q=0`, `out_q=0`, `drop_q=0`.
- **First request.** `icache_rd_o` rises in the first cycle after reset deasserts.
- **Latency.** Request accepted in cycle N, hit returned in N+1, `fetch_valid_o` in N+2.
- **Throughput.** 1 instr/cycle sustained on hits with `fetch_accept_i=1`.
- **Request hold.** `icache_pc_o`/`icache_rd_o` are held stable until accepted, except when a branch redirects. A redirect may change the PC of an unaccepted request.
- **Decode handshake.** `fetch_valid_o`/`fetch_instr_o`/`fetch_pc_o` are stable while `fetch_valid_o && !fetch_accept_i`.
- **Miss.** Cache refill stalls are absorbed by `out_q`; no timeout.
- **Fence.** From `fence_i_i` to first flush: 1 cycle + drain. The cache's own flush time is covered by `icache_accept_i` staying low.

## Structure
- `riscv_fetch_pkg`: `BOOT_VECTOR` default, FSM encoding (`FETCH_RUN`, `FETCH_DRAIN`, `FETCH_FLUSH`, 2 bits), FIFO entry width (65 = instr+pc+fault).
- Sub-module `riscv_fetch_fifo`: 2-entry, 65-bit; `push`/`pop`/`clear`, `valid`/`full`, `count`.
- Top holds the PC, outstanding tracking, drop logic and FSM.

## Test plan
- **Reset then hits, decode always ready:** PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 appear on consecutive cycles starting 2 cycles after the first accept.
- **Decode stalls 5 cycles:** exactly 2 entries buffered, `icache_rd_o` deasserts, no loss/duplication; resumes in order on release.
- **Branch to 0x1002 while a miss is outstanding:** the refill result is discarded; next `fetch_pc_o` is 0x1000.
- **Branch in the same cycle as `icache_valid_i`:** that instruction is dropped and the FIFO is empty next cycle.
- **`fence_i_i`, fence_pc 0x2000, during an outstanding lookup:** drain, then one accepted `icache_flush_o`, then first request PC 0x2000.
- **`icache_error_i` on PC 0x8000_0010:** `fetch_fault_o=1` for that entry only; the next sequential fetch (0x8000_0014) continues.
